// File: rtl/spi_slave_mode.sv
// SPI slave supporting all CPOL/CPHA modes and both bit orders. sck/ss/mosi are
// oversampled in the clk domain; TX uses a one-word holding register, RX emits a pulse.
module spi_slave_mode #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic            CPOL_L   = (CPOL != 0);
  localparam logic            CPHA_L   = (CPHA != 0);
  localparam logic            MSB_L    = (MSB_FIRST != 0);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0]      shift_rx_q, shift_rx_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   hold_full_q, hold_full_d;
  logic                   miso_q, miso_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   wrap_q, wrap_d;
  logic                   pend_q, pend_d;

  logic sck_s, ss_s, mosi_s, active;
  logic frame_start, frame_end, sck_edge, lead, trail;
  logic sample_e, shift_e, last, load, present, wr;
  logic [DATA_W-1:0] rx_next, tx_shifted;
  logic              tx_bit;

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign active      = ~ss_s;
  assign frame_start = ~ss_s & ss_prev_q;
  assign frame_end   = ss_s & ~ss_prev_q;
  assign sck_edge    = active & (sck_s != sck_prev_q);
  assign lead        = sck_edge & (sck_s != CPOL_L);
  assign trail       = sck_edge & (sck_s == CPOL_L);
  assign sample_e    = CPHA_L ? trail : lead;
  assign shift_e     = CPHA_L ? lead : trail;
  assign last        = sample_e & (cnt_q == LAST_CNT);
  assign wr          = tx_valid & ~hold_full_q;

  // CPHA=0 defers the next word's load to the shift edge after the last sample,
  // then presents its first bit one clk later (pend_q).
  assign load    = frame_start | (CPHA_L ? last : (shift_e & wrap_q));
  assign present = active & (CPHA_L ? shift_e : (pend_q | (shift_e & ~wrap_q)));

  assign rx_next    = MSB_L ? {shift_rx_q[DATA_W-2:0], mosi_s} : {mosi_s, shift_rx_q[DATA_W-1:1]};
  assign tx_bit     = MSB_L ? shift_tx_q[DATA_W-1] : shift_tx_q[0];
  assign tx_shifted = MSB_L ? {shift_tx_q[DATA_W-2:0], 1'b0} : {1'b0, shift_tx_q[DATA_W-1:1]};

  always_comb begin
    cnt_d       = cnt_q;
    shift_tx_d  = shift_tx_q;
    shift_rx_d  = shift_rx_q;
    hold_d      = wr ? tx_data : hold_q;
    hold_full_d = wr | (hold_full_q & ~load);
    rx_data_d   = rx_data_q;
    miso_d      = miso_q;
    rx_valid_d  = last;
    underrun_d  = load & ~hold_full_q;
    pend_d      = load & ~CPHA_L;
    wrap_d      = wrap_q;

    if (frame_end) begin
      shift_tx_d = '0;
    end else if (load) begin
      shift_tx_d = hold_full_q ? hold_q : '0;
    end else if (present) begin
      shift_tx_d = tx_shifted;
    end
    if (present) miso_d = tx_bit;

    if (frame_start || frame_end) begin
      cnt_d      = '0;
      shift_rx_d = '0;
      wrap_d     = 1'b0;
    end else begin
      if (sample_e) begin
        shift_rx_d = rx_next;
        cnt_d      = last ? '0 : cnt_q + 1'b1;
      end
      if (last) begin
        rx_data_d = rx_next;
        wrap_d    = 1'b1;
      end else if (shift_e) begin
        wrap_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= {SYNC_STAGES{CPOL_L}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= CPOL_L;
      ss_prev_q   <= 1'b1;
      cnt_q       <= '0;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      wrap_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      cnt_q       <= cnt_d;
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      wrap_q      <= wrap_d;
      pend_q      <= pend_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = ~ss_s;
  assign busy        = ~ss_s;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule
